// File: rtl/dbus_bridge.sv
// dbus_bridge: data-side bridge between the load/store control stage and the
// req/addr_ok/data_ok bus in front of the data cache.
//
// One access at a time: IDLE captures the SRAM-style request, REQ presents it
// on the bus until addr_ok, WAIT collects data_ok, DONE releases the pipeline
// for exactly one cycle. A flush during REQ/WAIT lets the bus transaction
// finish but drops its response and skips DONE.
//
// Optional build macro DBUS_POST_STORE_EN: stores retire on addr_ok and up to
// MAX_POSTED of them may have their data_ok still outstanding. Loads wait
// until every posted store has been answered.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_en/mem_wen/mem_addr/mem_wdata/data_size   request from the mem stage
//   flush               exception/ERET flush of the mem stage
//   mem_rdata           load data, valid in the DONE cycle, held afterwards
//   data_stall          holds the mem stage and everything before it
//   bus_req/bus_wr/bus_size/bus_addr/bus_wstrb/bus_wdata   bus request
//   bus_addr_ok/bus_data_ok/bus_rdata                      bus handshake
module dbus_bridge #(
    parameter int MAX_POSTED = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  data_size,
    input  logic        flush,
    output logic [31:0] mem_rdata,
    output logic        data_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic   kill, kill_nxt;
    logic   capture, rdata_ld;
    logic   cnt_zero, cnt_full, rsp_load;
    logic   unused_bits;

`ifdef DBUS_POST_STORE_EN
    localparam int CW = $clog2(MAX_POSTED + 1);

    logic [CW-1:0] posted;
    logic          post_inc, post_dec;

    // Any data_ok seen while stores are outstanding belongs to a store.
    assign post_dec = bus_data_ok && (posted != '0);
    assign cnt_zero = (posted == '0);
    assign cnt_full = (posted == CW'(MAX_POSTED));

    always_ff @(posedge clk) begin
        if (rst)
            posted <= '0;
        else if (post_inc && !post_dec)
            posted <= posted + CW'(1);
        else if (!post_inc && post_dec)
            posted <= posted - CW'(1);
    end

    assign unused_bits = data_size[2];
`else
    assign cnt_zero    = 1'b1;
    assign cnt_full    = 1'b0;
    assign unused_bits = ^{data_size[2], MAX_POSTED > 0};
`endif

    // A data_ok only answers the in-flight access when no posted store owns it.
    assign rsp_load = bus_data_ok && cnt_zero;

    always_comb begin
        state_nxt  = state;
        kill_nxt   = kill;
        capture    = 1'b0;
        rdata_ld   = 1'b0;
        data_stall = 1'b0;
        bus_req    = 1'b0;
`ifdef DBUS_POST_STORE_EN
        post_inc   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                // Stall follows the raw request even when capture is held off
                // by the posted-store limits.
                data_stall = mem_en && !flush;
                if (mem_en && !flush && ((|mem_wen) ? !cnt_full : cnt_zero)) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                data_stall = 1'b1;
                bus_req    = 1'b1;
                if (flush) kill_nxt = 1'b1;
                if (bus_addr_ok) begin
`ifdef DBUS_POST_STORE_EN
                    if (bus_wr) begin
                        // Posted store: retired now, response counted later.
                        post_inc  = 1'b1;
                        kill_nxt  = 1'b0;
                        state_nxt = (kill || flush) ? IDLE : DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
`else
                    state_nxt = WAIT;
`endif
                end
            end
            WAIT: begin
                data_stall = 1'b1;
                if (flush) kill_nxt = 1'b1;
                if (rsp_load) begin
                    // A flush arriving with the response also discards it.
                    if (kill || flush) begin
                        kill_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        rdata_ld  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kill      <= 1'b0;
            mem_rdata <= '0;
            bus_wr    <= 1'b0;
            bus_size  <= '0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
            // Bus fields come only from these registers, so they stay put
            // for as long as the request waits for addr_ok.
            if (capture) begin
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_wstrb <= mem_wen;
                bus_size  <= data_size[1:0];
                bus_wr    <= |mem_wen;
            end
            if (rdata_ld) mem_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
module tb_dbus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  data_size;
    logic        flush;
    logic [31:0] mem_rdata;
    logic        data_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

`ifdef DBUS_POST_STORE_EN
    localparam int MP = 2;
`else
    localparam int MP = 4;
`endif

    dbus_bridge #(.MAX_POSTED(MP)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .data_size(data_size),
        .flush(flush), .mem_rdata(mem_rdata), .data_stall(data_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } rsp_t;

    logic [70:0] req_q[$];   // {addr, wr, size, wstrb, wdata}
    rsp_t        done_q[$];
    rsp_t        mon_r;
    int tests = 0, fails = 0, accepts = 0, pushed = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [70:0] pack(input logic [31:0] a, input logic [3:0] wen,
                                         input logic [2:0] sz, input logic [31:0] wd);
        return {a, |wen, sz[1:0], wen, wd};
    endfunction

    function automatic logic [70:0] bus_now();
        return {bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata};
    endfunction

    // Monitor: checks every accepted request and every DONE cycle against queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req && bus_addr_ok) begin
                accepts++;
                if (req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: got addr %0h, expected no request", bus_addr);
                end else begin
                    chk("bus_req_fields", bus_now(), req_q.pop_front());
                end
            end
            if (mem_en && !flush && !data_stall) begin
                if (done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got completion rdata %0h, expected none", mem_rdata);
                end else begin
                    mon_r = done_q.pop_front();
                    if (mon_r.chk) chk("mem_rdata", mem_rdata, mon_r.data);
                end
            end
        end
    end

    // One access with the bench acting as bus slave. addr_ok comes after
    // aok_dly waiting REQ cycles, data_ok in the first WAIT cycle; with
    // kill_it the first WAIT cycle carries a flush and data_ok follows.
    task automatic xact(input string nm, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size, input int aok_dly,
                        input logic [31:0] rdata, input bit kill_it, input int exp_stall);
        int stalls = 0, nreq = 0, phase = 0;
        bit flushed = 0, stable = 1, ended = 0;
        req_q.push_back(pack(addr, wen, size, wdata));
        pushed++;
        if (!kill_it) done_q.push_back('{(wen == 4'h0), rdata});
        mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata; data_size = size;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!data_stall) begin ended = 1; break; end
            stalls++;
            if (bus_req && bus_now() !== pack(addr, wen, size, wdata)) stable = 0;
            @(posedge clk); #1;
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; flush = 1'b0; bus_rdata = 32'hBAD0BAD0;
            if (bus_req) begin
                if (nreq == aok_dly) begin bus_addr_ok = 1'b1; phase = 1; end
                nreq++;
            end else if (phase == 1) begin
                if (kill_it && !flushed) begin
                    flush = 1'b1; mem_en = 1'b0; flushed = 1;
                end else begin
                    bus_data_ok = 1'b1; bus_rdata = rdata; phase = 2;
                end
            end
        end
        chk({nm, "_completed"}, ended, 1'b1);
        chk({nm, "_stall_cycles"}, stalls, exp_stall);
        chk({nm, "_bus_stable"}, stable, 1'b1);
        chk({nm, "_req_cycles"}, nreq, aok_dly + 1);
        @(posedge clk); #1;
        mem_en = 1'b0; mem_wen = '0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    endtask

    task automatic step(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input bit aok, input bit dok, input logic [31:0] rd);
        @(posedge clk); #1;
        mem_en = en; mem_wen = wen; mem_addr = addr; mem_wdata = wdata; data_size = size;
        bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd;
        @(negedge clk);
    endtask

`ifdef DBUS_POST_STORE_EN
    logic [3:0]  p_wen [3];
    logic [31:0] p_dat [3];
    logic [2:0]  p_sz  [3];

    task automatic pst(input int i, input bit aok, input bit dok);
        step(1'b1, p_wen[i], 32'h3000 + 32'(i * 4), p_dat[i], p_sz[i], aok, dok, 32'h0);
    endtask

    task automatic pld(input bit aok, input bit dok, input logic [31:0] rd);
        step(1'b1, 4'h0, 32'h3010, 32'h0, 3'd2, aok, dok, rd);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_en = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0;
        data_size = '0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_stall", data_stall, 1'b0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_bus_regs", bus_now(), 71'h0);
        @(posedge clk); #1;

        xact("load_word", 4'h0, 32'h1000, 32'h0, 3'd2, 0, 32'hDEADBEEF, 1'b0, 3);
        xact("load_killed", 4'h0, 32'h1100, 32'h0, 3'd2, 0, 32'h12345678, 1'b1, 4);
        chk("kill_rdata_kept", mem_rdata, 32'hDEADBEEF);
`ifndef DBUS_POST_STORE_EN
        xact("store_byte", 4'b0100, 32'h2002, 32'h5A5A5A5A, 3'd0, 5, 32'h77777777, 1'b0, 8);
`endif
        xact("load_half", 4'h0, 32'h1006, 32'h0, 3'd1, 2, 32'h0000BEEF, 1'b0, 5);

        // Flush on the same cycle as a new request: nothing is captured.
        mem_en = 1'b1; flush = 1'b1; mem_addr = 32'h5000; data_size = 3'd2;
        @(negedge clk);
        chk("flush_idle_outputs", {data_stall, bus_req}, 2'b00);
        @(posedge clk); #1;
        mem_en = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_req", bus_req, 1'b0);

        // Reset while waiting for a load response; the late data_ok is ignored.
        @(posedge clk); #1;
        req_q.push_back(pack(32'h4000, 4'h0, 3'd2, 32'h0)); pushed++;
        mem_en = 1'b1; mem_addr = 32'h4000; data_size = 3'd2; mem_wdata = '0;
        @(posedge clk); #1;
        bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        chk("rst_wait_outputs", {data_stall, bus_req}, 2'b00);
        chk("rst_wait_rdata", mem_rdata, 32'h0);
        @(posedge clk); #1;
        bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("late_dok_rdata", mem_rdata, 32'h0);
        chk("late_dok_outputs", {data_stall, bus_req}, 2'b00);

`ifdef DBUS_POST_STORE_EN
        p_wen = '{4'hF, 4'h3, 4'h1};
        p_dat = '{32'h11111111, 32'h22222222, 32'h33333333};
        p_sz  = '{3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 3; i++) begin
            req_q.push_back(pack(32'h3000 + 32'(i * 4), p_wen[i], p_sz[i], p_dat[i]));
            pushed++;
            done_q.push_back('{1'b0, 32'h0});
        end
        req_q.push_back(pack(32'h3010, 4'h0, 3'd2, 32'h0)); pushed++;
        done_q.push_back('{1'b1, 32'h0BADF00D});

        pst(0, 0, 0); chk("p_s1_idle_stall", data_stall, 1'b1);
        pst(0, 1, 0); chk("p_s1_req", bus_req, 1'b1);
        pst(0, 0, 0); chk("p_s1_done", data_stall, 1'b0);
        pst(1, 0, 0); chk("p_s2_idle_stall", data_stall, 1'b1);
        pst(1, 1, 0); chk("p_s2_req", bus_req, 1'b1);
        pst(1, 0, 0); chk("p_s2_done", data_stall, 1'b0);
        for (int k = 0; k < 4; k++) begin
            pst(2, 0, k == 2);
            chk("p_s3_blocked", {data_stall, bus_req}, 2'b10);
        end
        pst(2, 1, 0); chk("p_s3_req", bus_req, 1'b1);
        pst(2, 0, 0); chk("p_s3_done", data_stall, 1'b0);
        for (int k = 0; k < 4; k++) begin
            pld(0, k == 1 || k == 2, 32'h0);
            chk("p_load_blocked", {data_stall, bus_req}, 2'b10);
        end
        pld(1, 0, 32'h0);          chk("p_load_req", bus_req, 1'b1);
        pld(0, 1, 32'h0BADF00D);   chk("p_load_wait", {data_stall, bus_req}, 2'b10);
        pld(0, 0, 32'h0);          chk("p_load_done", data_stall, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_drained", req_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        chk("accept_count", accepts, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Data-side bus bridge directly downstream of the load/store control stage.
- Consumes that stage's SRAM-style request (mem_en, mem_wen, mem_addr, mem_wdata, data_size) and runs one transaction on the req/addr_ok/data_ok data bus that feeds the data cache.
- Returns load data as mem_rdata and holds the pipeline with data_stall until the access completes.
- Discards responses for accesses killed by an exception flush.

Parameters:
- MAX_POSTED, 4: maximum outstanding posted stores; used only with DBUS_POST_STORE_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_en  in  1  access request from the load/store stage.
- mem_wen  in  4  byte write enables; nonzero means store.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, already lane-replicated.
- data_size  in  3  0=byte, 1=half, 2=word.
- flush  in  1  exception/ERET flush of the memory stage.
- mem_rdata  out  32  load data, valid while state is DONE.
- data_stall  out  1  hold the memory stage and all earlier stages.
- bus_req  out  1  request valid.
- bus_wr  out  1  1=write.
- bus_size  out  2  data_size[1:0].
- bus_addr  out  32  address.
- bus_wstrb  out  4  byte strobes.
- bus_wdata  out  32  write data.
- bus_addr_ok  in  1  request accepted this cycle.
- bus_data_ok  in  1  response this cycle; never in the same cycle as its own addr_ok.
- bus_rdata  in  32  read data, valid with bus_data_ok.

Behaviour:
- Reset: state=IDLE, kill=0, posted count=0, bus_req=0, all request registers=0, mem_rdata=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_en && !flush: latch addr, wdata, wstrb=mem_wen, size, wr=|mem_wen; go to REQ.
  - data_stall = mem_en && !flush, combinationally.
- REQ:
  - bus_req=1; bus_* driven only from the latched registers, stable until accepted.
  - bus_addr_ok -> WAIT. A request is never withdrawn once bus_req is high.
- WAIT:
  - bus_data_ok: if !kill, latch mem_rdata=bus_rdata (stores latch too; value don't-care) and go to DONE.
  - bus_data_ok with kill: clear kill, go to IDLE.
- DONE:
  - data_stall=0 for exactly one cycle; the pipeline advances at this edge.
  - mem_en is ignored; go to IDLE.
  - mem_rdata holds until the next latch.
- data_stall=1 in REQ and WAIT.
- flush in REQ or WAIT sets kill. The transaction still completes on the bus, its response is dropped, and DONE is skipped.
- flush in DONE has no effect; that access has already completed.
- flush in IDLE blocks capture that cycle.
- Minimum load latency: capture edge -> REQ -> WAIT -> DONE, so 4 cycles of mem_en with a 1-cycle addr_ok and a next-cycle data_ok; stall is high for 3 of them.
- bus_data_ok outside WAIT (and with no posted stores outstanding) is a protocol error; it is ignored and no state changes.

Optional Feature:
- Macro: DBUS_POST_STORE_EN.
- Defined:
  - Stores go REQ -> DONE on bus_addr_ok, and posted count increments.
  - Each bus_data_ok while posted count>0 decrements it and is consumed as a store response, never as load data.
  - IDLE does not capture a load while count>0, and does not capture a store while count==MAX_POSTED; data_stall stays high in either case.
  - flush never cancels posted stores.
  - Counter width is $clog2(MAX_POSTED+1); simultaneous increment and decrement leaves it unchanged.
- Undefined:
  - Stores wait for data_ok in WAIT like loads.
  - No counter is built.

Test Plan:
- Load: addr 0x1000, size 2, addr_ok 1 cycle after req, data_ok next cycle with 0xDEADBEEF -> bus_wr=0, bus_size=2, stall high 3 cycles, mem_rdata=0xDEADBEEF in DONE, exactly one bus_req acceptance.
- Store byte: wen 4'b0100, wdata 0x5A5A5A5A, addr 0x2002, addr_ok held low 5 cycles -> bus_req and bus_* stable all 5 cycles; bus_wr=1, bus_wstrb=4'b0100; DONE only after data_ok.
- Flush in WAIT during a load -> data_ok 0x12345678 is discarded, mem_rdata keeps its old value, no DONE cycle, next mem_en is captured normally.
- Flush same cycle as mem_en in IDLE -> no bus_req, data_stall=0.
- Reset asserted in WAIT -> next cycle state=IDLE, bus_req=0, mem_rdata=0; a late data_ok is ignored.
- DBUS_POST_STORE_EN, MAX_POSTED=2: 3 back-to-back stores with responses withheld -> first two complete on addr_ok, third stalls until one data_ok arrives; a following load stalls until count=0.
